// File: rtl/mux_arb_dest.sv
// Two-lane merge: per-lane FIFOs drained by a round-robin arbiter onto one
// registered, dest-tagged output stream.
module mux_arb_dest #(
  parameter int BITNUMBER = 5,
  parameter int DEPTH     = 4,
  parameter int AFULL_TH  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BITNUMBER-1:0] data_in0,
  input  logic                 valid_in0,
  input  logic [BITNUMBER-1:0] data_in1,
  input  logic                 valid_in1,
  input  logic                 pause_in,
  output logic [BITNUMBER-1:0] data_out,
  output logic                 valid_out,
  output logic                 dest_out,
  output logic                 almost_full0,
  output logic                 almost_full1,
  output logic                 overflow0,
  output logic                 overflow1
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [BITNUMBER-1:0] mem0 [DEPTH];
  logic [BITNUMBER-1:0] mem1 [DEPTH];
  logic [PW-1:0]        wr_ptr0, wr_ptr1, rd_ptr0, rd_ptr1;
  logic [CW-1:0]        count0, count1;
  logic                 last_grant;

  logic ne0, ne1, full0, full1, wr0, wr1, pop, sel, pop0, pop1;
  logic [BITNUMBER-1:0] head;

  always_comb begin
    ne0   = (count0 != '0);
    ne1   = (count1 != '0);
    full0 = (count0 == CW'(DEPTH));
    full1 = (count1 == CW'(DEPTH));
    wr0   = valid_in0 && !full0;
    wr1   = valid_in1 && !full1;
    pop   = !pause_in && (ne0 || ne1);
    // Under contention the lane not served last time wins.
    sel   = (ne0 && ne1) ? ~last_grant : ne1;
    pop0  = pop && !sel;
    pop1  = pop && sel;
    head  = sel ? mem1[rd_ptr1] : mem0[rd_ptr0];
  end

  assign almost_full0 = (count0 >= CW'(AFULL_TH));
  assign almost_full1 = (count1 >= CW'(AFULL_TH));

  // Storage has no reset; pointers and counts make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (wr0) mem0[wr_ptr0] <= data_in0;
    if (wr1) mem1[wr_ptr1] <= data_in1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr0    <= '0;
      wr_ptr1    <= '0;
      rd_ptr0    <= '0;
      rd_ptr1    <= '0;
      count0     <= '0;
      count1     <= '0;
      last_grant <= 1'b1;
      overflow0  <= 1'b0;
      overflow1  <= 1'b0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      dest_out   <= 1'b0;
    end else begin
      if (wr0) wr_ptr0 <= wr_ptr0 + PW'(1);
      if (wr1) wr_ptr1 <= wr_ptr1 + PW'(1);
      if (pop0) rd_ptr0 <= rd_ptr0 + PW'(1);
      if (pop1) rd_ptr1 <= rd_ptr1 + PW'(1);

      case ({wr0, pop0})
        2'b10:   count0 <= count0 + CW'(1);
        2'b01:   count0 <= count0 - CW'(1);
        default: count0 <= count0;
      endcase
      case ({wr1, pop1})
        2'b10:   count1 <= count1 + CW'(1);
        2'b01:   count1 <= count1 - CW'(1);
        default: count1 <= count1;
      endcase

      if (valid_in0 && full0) overflow0 <= 1'b1;
      if (valid_in1 && full1) overflow1 <= 1'b1;

      // Output register stage
      if (pop) begin
        data_out   <= head;
        valid_out  <= 1'b1;
        dest_out   <= sel;
        last_grant <= sel;
      end else begin
        data_out  <= '0;
        valid_out <= 1'b0;
        dest_out  <= 1'b0;
      end
    end
  end

endmodule
